vga_fb_fetch: RTL and testbench



---
 rtl/vga_fb_fetch.sv | 119 +++++++++++
 tb/tb_vga_fb_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: fetches a framebuffer over AXI4 read bursts into a 64-bit line FIFO
// and unpacks each word into four RGB444 pixels for the display timing path.
module vga_fb_fetch #(
    parameter int BURST_LEN   = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int FRAME_BEATS = 76800
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] io_offset,
    input  logic        frame_start,
    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [63:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [11:0] pix_data,
    output logic        underflow,
    output logic        rd_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_BEATS + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t         state, state_nx;
    logic [31:0]    base;
    logic [CW-1:0]  fetch_cnt;
    logic           frame_active;
    logic [63:0]    mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr, count;
    logic [1:0]     idx;
    logic [63:0]    head;
    logic           push, pop, room, last_beat;
    logic           unused_rid;

    assign io_master_arid    = '0;
    assign io_master_arlen   = 8'(BURST_LEN - 1);
    assign io_master_arsize  = 3'd3;
    assign io_master_arburst = 2'b01;
    assign io_master_arvalid = state == ADDR;
    assign io_master_rready  = state == DATA || state == DRAIN;
    assign io_master_araddr  = base + 32'({fetch_cnt, 3'b000});
    assign unused_rid        = ^io_master_rid;

    assign count     = wr_ptr - rd_ptr;
    assign pix_valid = count != '0;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign pix_data  = pix_valid ? 12'(head >> {idx, 4'b0000}) : '0;
    // A frame restart flushes the FIFO, so beats and pops in that cycle are dropped.
    assign push      = state == DATA && io_master_rvalid && !frame_start;
    assign pop       = pix_ready && pix_valid && idx == 2'd3 && !frame_start;
    assign room      = int'(count) + BURST_LEN <= FIFO_DEPTH;
    assign last_beat = io_master_rvalid && io_master_rlast;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = (frame_active && room && !frame_start) ? ADDR : IDLE;
            ADDR:  state_nx = io_master_arready ? (frame_start ? DRAIN : DATA)
                                                : (frame_start ? IDLE : ADDR);
            DATA:  state_nx = last_beat ? IDLE : (frame_start ? DRAIN : DATA);
            DRAIN: state_nx = last_beat ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            base         <= '0;
            fetch_cnt    <= '0;
            frame_active <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            idx          <= '0;
            underflow    <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            state <= state_nx;
            if (frame_start) begin
                base         <= io_offset;
                fetch_cnt    <= '0;
                frame_active <= 1'b1;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                idx          <= '0;
                underflow    <= 1'b0;
                rd_err       <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr       <= wr_ptr + 1'b1;
                    fetch_cnt    <= fetch_cnt + 1'b1;
                    rd_err       <= rd_err | (io_master_rresp != 2'b00);
                    frame_active <= fetch_cnt != CW'(FRAME_BEATS - 1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (pix_ready && pix_valid)
                    idx <= idx + 1'b1;
                if (pix_ready && !pix_valid)
                    underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock)
        if (push)
            mem[wr_ptr[AW-1:0]] <= io_master_rdata;
endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb_vga_fb_fetch: AXI memory model plus a frame-level pixel reference for vga_fb_fetch.
module tb_vga_fb_fetch;
    localparam int BL = 16;
    localparam int FD = 32;
    localparam int FB = 64;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] io_offset;
    logic        frame_start;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid, rlast;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic        pix_ready, pix_valid, underflow, rd_err;
    logic [11:0] pix_data;

    always #5 clock = ~clock;

    vga_fb_fetch #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .FRAME_BEATS(FB)) dut (
        .clock(clock), .resetn(resetn), .io_offset(io_offset), .frame_start(frame_start),
        .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arburst(arburst), .io_master_rready(rready), .io_master_rvalid(rvalid),
        .io_master_rresp(rresp), .io_master_rdata(rdata), .io_master_rlast(rlast),
        .io_master_rid(rid), .pix_ready(pix_ready), .pix_valid(pix_valid),
        .pix_data(pix_data), .underflow(underflow), .rd_err(rd_err)
    );

    typedef struct packed {
        logic [31:0] off;
        logic [63:0] data;
        logic [1:0]  resp;
        logic [47:0] pix;
        logic        err;
    } vec_t;

    vec_t        vecs [4];
    int          errors = 0, checks = 0;
    int          rv_pct, ar_pct, pix_pct;
    logic [31:0] ar_q [$];
    int          beat, rb, ar_cnt, pix_n;
    logic [31:0] cur_base;
    logic        exp_uf;
    logic        ovr_en;
    logic [31:0] ovr_addr;
    logic [63:0] ovr_data;
    logic [1:0]  ovr_resp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr)
            return ovr_data;
        return {a ^ 32'hC3A5_5A3C, ~a + 32'h0001_2345};
    endfunction

    // Pixel n of a frame at base b: word n/4 of the linear framebuffer, 16-bit lanes low first.
    function automatic logic [11:0] exp_pix(input logic [31:0] b, input int n);
        logic [63:0] w;
        w = mem_word(b + 32'(n / 4) * 32'd8);
        return 12'(w >> (16 * (n % 4)));
    endfunction

    task automatic tick();
        logic ar_f, r_f, p_f, last;
        logic [31:0] aa, a;
        ar_f = arvalid && arready;
        r_f  = rvalid && rready;
        p_f  = pix_ready && pix_valid;
        last = rlast;
        aa   = araddr;
        check("underflow", 64'(underflow), 64'(exp_uf));
        if (p_f && !frame_start) begin
            check("pix_data", 64'(pix_data), 64'(exp_pix(cur_base, pix_n)));
            pix_n++;
        end
        if (pix_ready && !pix_valid && !frame_start)
            check("pix_zero", 64'(pix_data), 64'(0));
        if (ar_f && !frame_start) begin
            check("araddr", 64'(aa), 64'(cur_base + 32'(ar_cnt) * 32'd128));
            ar_cnt++;
        end
        if (r_f)
            rb++;
        if (frame_start) begin
            cur_base = io_offset;
            pix_n = 0;
            ar_cnt = 0;
            rb = 0;
            exp_uf = 1'b0;
        end else if (pix_ready && !pix_valid)
            exp_uf = 1'b1;
        @(posedge clock);
        if (r_f) begin
            beat++;
            if (last) begin
                void'(ar_q.pop_front());
                beat = 0;
            end
        end
        if (ar_f)
            ar_q.push_back(aa);
        @(negedge clock);
        frame_start = 1'b0;
        if (!(rvalid && !r_f)) begin
            rvalid = ar_q.size() > 0 && int'($urandom_range(99)) < rv_pct;
            if (rvalid) begin
                a = ar_q[0] + 32'(beat) * 32'd8;
                rdata = mem_word(a);
                rresp = (ovr_en && a == ovr_addr) ? ovr_resp : 2'b00;
                rlast = beat == BL - 1;
            end else
                rlast = 1'b0;
        end
        arready = int'($urandom_range(99)) < ar_pct;
        pix_ready = int'($urandom_range(99)) < pix_pct;
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] off);
        io_offset = off;
        frame_start = 1'b1;
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h1000_0000, 64'h0ABC_0DEF_0123_0456, 2'd0, {12'hABC, 12'hDEF, 12'h123, 12'h456}, 1'b0};
        vecs[1] = '{32'h2000_0040, 64'hFFFF_F00F_1234_8765, 2'd2, {12'hFFF, 12'h00F, 12'h234, 12'h765}, 1'b1};
        vecs[2] = '{32'hFFFF_FFF8, 64'h1111_2222_3333_4444, 2'd3, {12'h111, 12'h222, 12'h333, 12'h444}, 1'b1};
        vecs[3] = '{32'h0000_0000, 64'h0F0F_F0F0_00FF_FF00, 2'd0, {12'hF0F, 12'h0F0, 12'h0FF, 12'hF00}, 1'b0};
        resetn = 1'b0; io_offset = '0; frame_start = 1'b0; arready = 1'b0; rvalid = 1'b0;
        rresp = '0; rdata = '0; rlast = 1'b0; rid = '0; pix_ready = 1'b0;
        rv_pct = 100; ar_pct = 100; pix_pct = 0; ovr_en = 1'b0; ovr_addr = '0; ovr_data = '0;
        ovr_resp = '0; beat = 0; rb = 0; ar_cnt = 0; pix_n = 0; cur_base = '0; exp_uf = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_rready", 64'(rready), 64'(0));
        check("rst_pix_valid", 64'(pix_valid), 64'(0));
        check("rst_pix_data", 64'(pix_data), 64'(0));
        check("rst_underflow", 64'(underflow), 64'(0));
        check("rst_rd_err", 64'(rd_err), 64'(0));
        check("arlen", 64'(arlen), 64'(15));
        check("arsize", 64'(arsize), 64'(3));
        check("arburst", 64'(arburst), 64'(1));
        check("arid", 64'(arid), 64'(0));
        resetn = 1'b1;
        #1;
        repeat (5) tick();
        check("no_frame_ar", 64'(ar_cnt), 64'(0));

        // Two bursts fill the FIFO; the third waits for 16 words of space.
        pulse_start(32'h8000_0000);
        repeat (100) tick();
        check("two_bursts", 64'(ar_cnt), 64'(2));
        check("fifo_full_valid", 64'(pix_valid), 64'(1));
        pix_pct = 100; pix_ready = 1'b1;
        repeat (60) tick();
        pix_pct = 0; pix_ready = 1'b0;
        check("pop60", 64'(pix_n), 64'(60));
        repeat (20) tick();
        check("no_third_ar", 64'(ar_cnt), 64'(2));
        pix_pct = 100; pix_ready = 1'b1;
        repeat (4) tick();
        pix_pct = 0; pix_ready = 1'b0;
        for (int t = 0; t < 20 && ar_cnt < 3; t++) tick();
        check("third_ar", 64'(ar_cnt), 64'(3));

        // Finish the frame with random handshakes, then no more fetches.
        rv_pct = 70; ar_pct = 50; pix_pct = 60;
        for (int t = 0; t < 4000 && pix_n < 4 * FB; t++) tick();
        check("frame_pixels", 64'(pix_n), 64'(4 * FB));
        check("frame_ars", 64'(ar_cnt), 64'(4));
        pix_pct = 0;
        repeat (40) tick();
        check("frame_done_ars", 64'(ar_cnt), 64'(4));
        check("frame_done_arvalid", 64'(arvalid), 64'(0));

        // Restart after 5 beats of a burst: rest is drained, new base used.
        rv_pct = 100; ar_pct = 100; pix_pct = 0;
        pulse_start(32'h0000_1000);
        for (int t = 0; t < 50 && rb < 5; t++) tick();
        check("five_beats", 64'(rb), 64'(5));
        pulse_start(32'h0000_2000);
        check("flush_empty", 64'(pix_valid), 64'(0));
        for (int t = 0; t < 50 && ar_cnt < 1; t++) tick();
        check("restart_ar", 64'(ar_cnt), 64'(1));
        check("flush_hold", 64'(pix_valid), 64'(0));

        // Table of single-word frames: pixel order, error flag, wrap-around base.
        for (int i = 0; i < 4; i++) begin
            ovr_en = 1'b1; ovr_addr = vecs[i].off; ovr_data = vecs[i].data; ovr_resp = vecs[i].resp;
            pix_pct = 0; pix_ready = 1'b0;
            pulse_start(vecs[i].off);
            for (int t = 0; t < 80 && !pix_valid; t++) tick();
            check("tbl_valid", 64'(pix_valid), 64'(1));
            pix_pct = 100; pix_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                check("tbl_pix", 64'(pix_data), 64'(vecs[i].pix[12*k +: 12]));
                tick();
            end
            pix_pct = 0; pix_ready = 1'b0;
            check("tbl_err", 64'(rd_err), 64'(vecs[i].err));
        end
        ovr_en = 1'b0;

        // Starved consumer: sticky underflow with zero pixel data.
        rv_pct = 0;
        pulse_start(32'h0000_4000);
        pix_pct = 100; pix_ready = 1'b1;
        repeat (5) tick();
        check("uf_set", 64'(underflow), 64'(1));
        check("uf_data", 64'(pix_data), 64'(0));
        rv_pct = 100;
        repeat (30) tick();
        check("uf_sticky", 64'(underflow), 64'(1));
        for (int t = 0; t < 40 && beat == 0; t++) tick();
        check("mid_burst", 64'(beat != 0), 64'(1));

        // Asynchronous reset in the middle of a burst.
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_arvalid", 64'(arvalid), 64'(0));
        check("arst_rready", 64'(rready), 64'(0));
        check("arst_pix_valid", 64'(pix_valid), 64'(0));
        check("arst_pix_data", 64'(pix_data), 64'(0));
        check("arst_underflow", 64'(underflow), 64'(0));
        check("arst_rd_err", 64'(rd_err), 64'(0));
        ar_q.delete(); beat = 0; rvalid = 1'b0; rlast = 1'b0; pix_ready = 1'b0; pix_pct = 0;
        exp_uf = 1'b0; ar_cnt = 0;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        repeat (10) tick();
        check("arst_idle", 64'(ar_cnt), 64'(0));
        pulse_start(32'h0000_8000);
        for (int t = 0; t < 30 && ar_cnt < 1; t++) tick();
        check("arst_new_ar", 64'(ar_cnt), 64'(1));
        check("arst_uf_clear", 64'(underflow), 64'(0));

        // Random full frames against the frame-level model.
        for (int f = 0; f < 3; f++) begin
            logic [31:0] off;
            off = $urandom();
            off[2:0] = 3'b000;
            rv_pct = int'($urandom_range(100, 30));
            ar_pct = int'($urandom_range(100, 30));
            pix_pct = int'($urandom_range(100, 30));
            pulse_start(off);
            for (int t = 0; t < 6000 && pix_n < 4 * FB; t++) tick();
            check("rnd_pixels", 64'(pix_n), 64'(4 * FB));
            check("rnd_ars", 64'(ar_cnt), 64'(4));
            repeat (40) tick();
            check("rnd_no_more_ar", 64'(ar_cnt), 64'(4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
